// File: rtl/bin_to_bcd_seq_if.sv
// Valid/ready bundle between a binary producer and the BCD converter.
// master: drives in_data/in_valid; slave: converter, drives result side.
interface bin_to_bcd_seq_if #(
   parameter int w_bin   = 16,
   parameter int w_digit = 4
);
   logic [w_bin-1:0]     in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [w_digit*4-1:0] bcd;
   logic                 out_valid;
   logic                 overflow;
   logic                 negative;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  bcd,
      input  out_valid,
      input  overflow,
      input  negative
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output bcd,
      output out_valid,
      output overflow,
      output negative
   );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary to packed BCD, one bit per clock.
// Ports: clk, rst_n (async low), bus (slave): in_data/in_valid/in_ready,
// bcd/out_valid/overflow/negative. Macro BIN_TO_BCD_SIGNED_EN: signed input.
module bin_to_bcd_seq #(
   parameter int w_bin   = 16,
   parameter int w_digit = 4
) (
   input logic             clk,
   input logic             rst_n,
   bin_to_bcd_seq_if.slave bus
);
   localparam int W_INT = w_bin / 3 + 1;
   localparam int W_ACC = W_INT * 4;
   localparam int W_BCD = w_digit * 4;
   localparam int W_EXT = (w_digit > W_INT) ? W_BCD : W_ACC;
   localparam int W_CNT = $clog2(w_bin + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q;
   logic [W_ACC-1:0] acc_q;
   logic [W_ACC-1:0] acc_adj;
   logic [W_ACC-1:0] acc_d;
   logic [w_bin-1:0] sr_q;
   logic [w_bin-1:0] sr_d;
   logic [w_bin-1:0] load_val;
   logic [W_CNT-1:0] cnt_q;
   logic [W_EXT-1:0] acc_ext;
   logic [W_BCD-1:0] bcd_q;
   logic [W_BCD-1:0] bcd_d;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             overflow_q;
   logic             overflow_d;
   logic             negative_q;
   logic             negative_d;
   logic             hs;
   logic             last;

`ifdef BIN_TO_BCD_SIGNED_EN
   logic sign_q;
   logic load_sgn;

   assign load_sgn   = bus.in_data[w_bin-1];
   // -2^(w_bin-1) negates to itself, which is the correct unsigned magnitude
   assign load_val   = load_sgn ? -bus.in_data : bus.in_data;
   assign negative_d = sign_q & (|acc_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_q <= 1'b0;
      end else if (hs) begin
         sign_q <= load_sgn;
      end
   end
`else
   assign load_val   = bus.in_data;
   assign negative_d = 1'b0;
`endif

   assign hs   = bus.in_valid & in_ready_q;
   assign last = (cnt_q == W_CNT'(1));

   always_comb begin
      acc_adj = acc_q;
      for (int k = 0; k < W_INT; k++) begin
         if (acc_q[4*k +: 4] >= 4'd5) begin
            acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
         end
      end
      acc_d   = {acc_adj[W_ACC-2:0], sr_q[w_bin-1]};
      sr_d    = {sr_q[w_bin-2:0], 1'b0};
      // zero-extend so a wide display gets blank upper digits
      acc_ext = '0;
      acc_ext[W_ACC-1:0] = acc_d;
      bcd_d   = acc_ext[W_BCD-1:0];
      overflow_d = 1'b0;
      for (int k = w_digit; k < W_INT; k++) begin
         overflow_d = overflow_d | (acc_d[4*k +: 4] != 4'd0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         sr_q        <= '0;
         cnt_q       <= '0;
         bcd_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         negative_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               out_valid_q <= 1'b0;
            end
            SHIFT: begin
               acc_q       <= acc_d;
               sr_q        <= sr_d;
               cnt_q       <= cnt_q - W_CNT'(1);
               out_valid_q <= 1'b0;
               // ready opens during the final shift so the next accept
               // overlaps the result edge
               in_ready_q  <= (cnt_q == W_CNT'(2));
               if (last) begin
                  bcd_q       <= bcd_d;
                  overflow_q  <= overflow_d;
                  negative_q  <= negative_d;
                  out_valid_q <= 1'b1;
                  in_ready_q  <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
         // accept overrides the per-state updates above
         if (hs) begin
            sr_q       <= load_val;
            acc_q      <= '0;
            cnt_q      <= W_CNT'(w_bin);
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.bcd       = bcd_q;
   assign bus.overflow  = overflow_q;
   assign bus.negative  = negative_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq.
// Unsigned vectors by default; signed vectors when BIN_TO_BCD_SIGNED_EN.
module tb_bin_to_bcd_seq;
`ifdef BIN_TO_BCD_SIGNED_EN
   localparam int W_DIGIT = 5;
`else
   localparam int W_DIGIT = 4;
`endif

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   bin_to_bcd_seq_if #(.w_bin(16), .w_digit(W_DIGIT)) bus ();

   bin_to_bcd_seq #(
      .w_bin   (16),
      .w_digit (W_DIGIT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic convert(input logic [15:0] v,
                          input logic [31:0] eb,
                          input logic        ev,
                          input logic        en);
      int w;
      int lat;
      int low;
      w = 0;
      while (!bus.in_ready && w < 40) begin
         tick();
         w++;
      end
      check("ready_wait", 32'(w < 40), 32'd1);
      bus.in_data  = v;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      low = 0;
      while (!bus.out_valid && lat < 40) begin
         if (!bus.in_ready) low++;
         bus.in_data = 16'($urandom);
         tick();
         lat++;
      end
      check("latency", 32'(lat), 32'd16);
      check("ready_low", 32'(low), 32'd15);
      check("bcd", 32'(bus.bcd), eb);
      check("overflow", 32'(bus.overflow), 32'(ev));
      check("negative", 32'(bus.negative), 32'(en));
      tick();
      check("ov_pulse", 32'(bus.out_valid), 32'd0);
   endtask

`ifndef BIN_TO_BCD_SIGNED_EN
   task automatic stream();
      logic [15:0] vals [3];
      logic [31:0] exps [3];
      int sent;
      int lat;
      bit hs;
      vals = '{16'd1, 16'd42, 16'd500};
      exps = '{32'h0001, 32'h0042, 32'h0500};
      bus.in_data  = vals[0];
      bus.in_valid = 1'b1;
      tick();
      sent = 1;
      for (int n = 0; n < 3; n++) begin
         lat = 0;
         do begin
            if (bus.in_ready) begin
               if (sent < 3) bus.in_data = vals[sent];
               else bus.in_valid = 1'b0;
            end else begin
               bus.in_data = 16'($urandom);
            end
            hs = bus.in_ready && bus.in_valid;
            tick();
            if (hs) sent++;
            lat++;
         end while (!bus.out_valid && lat < 40);
         check("stream_gap", 32'(lat), 32'd16);
         check("stream_bcd", 32'(bus.bcd), exps[n]);
      end
      bus.in_valid = 1'b0;
      tick();
      check("stream_end", 32'(bus.out_valid), 32'd0);
   endtask

   task automatic reset_abort();
      int seen;
      bus.in_data  = 16'd4321;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (7) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_ready", 32'(bus.in_ready), 32'd1);
      check("rst_ov", 32'(bus.out_valid), 32'd0);
      check("rst_bcd", 32'(bus.bcd), 32'd0);
      check("rst_ovf", 32'(bus.overflow), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         tick();
         if (bus.out_valid) seen++;
      end
      check("abort_ov", 32'(seen), 32'd0);
      convert(16'd7, 32'h0007, 1'b0, 1'b0);
   endtask
`endif

   initial begin
      n_cmp        = 0;
      n_err        = 0;
      rst_n        = 1'b0;
      bus.in_data  = '0;
      bus.in_valid = 1'b0;
      repeat (2) tick();
      check("init_ready", 32'(bus.in_ready), 32'd1);
      check("init_ov", 32'(bus.out_valid), 32'd0);
      check("init_bcd", 32'(bus.bcd), 32'd0);
      check("init_ovf", 32'(bus.overflow), 32'd0);
      check("init_neg", 32'(bus.negative), 32'd0);
      rst_n = 1'b1;
      tick();
`ifdef BIN_TO_BCD_SIGNED_EN
      convert(16'hFFFF, 32'h00001, 1'b0, 1'b1);
      convert(16'h8000, 32'h32768, 1'b0, 1'b1);
      convert(16'd0, 32'h00000, 1'b0, 1'b0);
      convert(16'd1234, 32'h01234, 1'b0, 1'b0);
      convert(16'h7FFF, 32'h32767, 1'b0, 1'b0);
`else
      convert(16'd1234, 32'h1234, 1'b0, 1'b0);
      convert(16'd0, 32'h0000, 1'b0, 1'b0);
      convert(16'd9999, 32'h9999, 1'b0, 1'b0);
      convert(16'd10000, 32'h0000, 1'b1, 1'b0);
      convert(16'hFFFF, 32'h5535, 1'b1, 1'b0);
      stream();
      reset_abort();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
